// File: rtl/ir_dispatch_seq.sv
// rtl/ir_dispatch_seq.sv - IR load and DRAM dispatch lookup sequencer
module ir_dispatch_seq #(
   parameter int DRAM_LAT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         loadCache,
   input  logic         loadAD,
   input  logic [0:35]  cacheData,
   input  logic [0:35]  AD,
   input  logic         userMode,
   input  logic         userIOEn,
   input  logic         ackDisp,
   input  logic [23:0]  dramData,
   output logic         dramEn,
   output logic [0:12]  dramAddr,
   output logic [10:12] irac,
   output logic         irIOLegal,
   output logic         JRST0,
   output logic [3:0]   DRAM_A,
   output logic [3:0]   DRAM_B,
   output logic [10:0]  DRAM_J,
   output logic         dramParErr,
   output logic         dispValid,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_CAP,
      S_VALID
   } state_t;

   // Last WAIT count before CAP; WAIT is never entered when DRAM_LAT is 1.
   localparam logic [1:0] WAIT_LAST = (DRAM_LAT > 1) ? 2'(DRAM_LAT - 2) : 2'd0;

   state_t      state;
   logic [0:35] ir;
   logic [1:0]  wait_cnt;
   logic        accept;
   logic        new_io;
   logic [0:35] new_ir;
   logic        unused_bits;

   // Source select (cache wins) and load acceptance: idle, or consumer acking a valid result.
   always_comb begin
      new_ir = loadCache ? cacheData : AD;
      new_io = (new_ir[0:2] == 3'b111);
      accept = (loadCache | loadAD) &&
               ((state == S_IDLE) || ((state == S_VALID) && ackDisp));
   end

   // The full IR is architecturally held; only its decoded fields leave the block.
   assign unused_bits = ^{ir, dramData[15:11]};

   // Sequencer: IR capture and decode, DRAM read timing, dispatch result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ir         <= '0;
         irac       <= '0;
         JRST0      <= 1'b0;
         irIOLegal  <= 1'b0;
         dramAddr   <= '0;
         DRAM_A     <= '0;
         DRAM_B     <= '0;
         DRAM_J     <= '0;
         dramParErr <= 1'b0;
         dispValid  <= 1'b0;
         dramEn     <= 1'b0;
         busy       <= 1'b0;
         wait_cnt   <= '0;
      end else if (accept) begin
         ir        <= new_ir;
         irac      <= new_ir[10:12];
         JRST0     <= (new_ir[0:8] == 9'o254) && (new_ir[9:12] == 4'd0);
         irIOLegal <= new_io && (!userMode || userIOEn);
         dramAddr  <= {new_ir[0:8], new_ir[10:12], new_io};
         dramEn    <= 1'b1;
         busy      <= 1'b1;
         dispValid <= 1'b0;
         wait_cnt  <= '0;
         state     <= S_RD;
      end else begin
         case (state)
            S_RD: begin
               dramEn <= 1'b0;
               if (DRAM_LAT > 1) state <= S_WAIT;
               else              state <= S_CAP;
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= S_CAP;
               else                       wait_cnt <= wait_cnt + 2'd1;
            end
            S_CAP: begin
               DRAM_A     <= dramData[23:20];
               DRAM_B     <= dramData[19:16];
               DRAM_J     <= dramData[10:0];
               dramParErr <= ~^dramData;
               dispValid  <= 1'b1;
               busy       <= 1'b0;
               state      <= S_VALID;
            end
            S_VALID: begin
               if (ackDisp) begin
                  dispValid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_dispatch_seq.sv
// tb/tb_ir_dispatch_seq.sv - scoreboard bench for ir_dispatch_seq at DRAM_LAT 1 and 3
module tb_ir_dispatch_seq;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic [10:0] j;
      logic        par;
      int unsigned due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        load_cache [2];
   logic        load_ad    [2];
   logic        user_mode  [2];
   logic        user_io_en [2];
   logic        ack_disp   [2];
   logic [35:0] cache_data [2];
   logic [35:0] ad_word    [2];
   logic [23:0] dram_data  [2];
   logic        dram_en    [2];
   logic [12:0] dram_addr  [2];
   logic [2:0]  irac       [2];
   logic        io_legal   [2];
   logic        jrst0      [2];
   logic [3:0]  dram_a     [2];
   logic [3:0]  dram_b     [2];
   logic [10:0] dram_j     [2];
   logic        par_err    [2];
   logic        disp_valid [2];
   logic        busy       [2];

   ir_dispatch_seq #(.DRAM_LAT(LAT0)) u_lat1 (
      .clk(clk), .reset(reset), .loadCache(load_cache[0]), .loadAD(load_ad[0]),
      .cacheData(cache_data[0]), .AD(ad_word[0]), .userMode(user_mode[0]),
      .userIOEn(user_io_en[0]), .ackDisp(ack_disp[0]), .dramData(dram_data[0]),
      .dramEn(dram_en[0]), .dramAddr(dram_addr[0]), .irac(irac[0]),
      .irIOLegal(io_legal[0]), .JRST0(jrst0[0]), .DRAM_A(dram_a[0]), .DRAM_B(dram_b[0]),
      .DRAM_J(dram_j[0]), .dramParErr(par_err[0]), .dispValid(disp_valid[0]), .busy(busy[0])
   );

   ir_dispatch_seq #(.DRAM_LAT(LAT1)) u_lat3 (
      .clk(clk), .reset(reset), .loadCache(load_cache[1]), .loadAD(load_ad[1]),
      .cacheData(cache_data[1]), .AD(ad_word[1]), .userMode(user_mode[1]),
      .userIOEn(user_io_en[1]), .ackDisp(ack_disp[1]), .dramData(dram_data[1]),
      .dramEn(dram_en[1]), .dramAddr(dram_addr[1]), .irac(irac[1]),
      .irIOLegal(io_legal[1]), .JRST0(jrst0[1]), .DRAM_A(dram_a[1]), .DRAM_B(dram_b[1]),
      .DRAM_J(dram_j[1]), .dramParErr(par_err[1]), .dispValid(disp_valid[1]), .busy(busy[1])
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;

   // Reference model: one outstanding lookup per instance, timed in edge numbers.
   bit          out      [2];
   int unsigned due      [2];
   int unsigned acc_edge [2];
   logic [12:0] m_addr   [2];
   logic [2:0]  m_irac   [2];
   logic        m_jrst   [2];
   logic        m_legal  [2];
   exp_t        sb0 [$];
   exp_t        sb1 [$];
   logic        prev_v [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int lat_of(input int i);
      return (i == 0) ? LAT0 : LAT1;
   endfunction

   function automatic bit io_of(input logic [35:0] w);
      return (w >> 33) == 36'd7;
   endfunction

   function automatic logic [12:0] addr_of(input logic [35:0] w);
      int unsigned op, ac;
      op = 32'(w >> 27);
      ac = 32'((w >> 23) % 8);
      return 13'(op * 16 + ac * 2 + (io_of(w) ? 1 : 0));
   endfunction

   function automatic logic [35:0] rand_word();
      logic [35:0] w;
      w = {4'($urandom_range(0, 15)), $urandom};
      if ($urandom_range(0, 3) == 0) w[35:33] = 3'b111;
      if ($urandom_range(0, 7) == 0) begin
         w[35:27] = 9'o254;
         w[26:23] = 4'd0;
      end
      return w;
   endfunction

   // One clock of stimulus on instance i; model decides acceptance, queues the expected result.
   task automatic step(input int i, input bit lc, input bit la, input logic [35:0] cw,
                       input logic [35:0] aw, input bit um, input bit uio, input bit ack,
                       input logic [23:0] dd);
      int unsigned e;
      bit          in_valid, acc;
      logic [35:0] w;
      exp_t        x;
      @(negedge clk);
      e        = cyc + 1;
      in_valid = out[i] && (e >= due[i] + 1);
      acc      = (lc || la) && (!out[i] || (in_valid && ack));
      if (in_valid && ack) out[i] = 1'b0;
      load_cache[i] = lc;
      load_ad[i]    = la;
      cache_data[i] = cw;
      ad_word[i]    = aw;
      user_mode[i]  = um;
      user_io_en[i] = uio;
      ack_disp[i]   = ack;
      if (acc) begin
         w            = lc ? cw : aw;
         dram_data[i] = dd;
         out[i]       = 1'b1;
         acc_edge[i]  = e;
         due[i]       = e + lat_of(i) + 1;
         m_addr[i]    = addr_of(w);
         m_irac[i]    = 3'((w >> 23) % 8);
         m_jrst[i]    = ((w >> 27) == 36'o254) && (((w >> 23) % 16) == 0);
         m_legal[i]   = io_of(w) && (!um || uio);
         x.a   = dd[23:20];
         x.b   = dd[19:16];
         x.j   = dd[10:0];
         x.par = ($countones(dd) % 2) == 0;
         x.due = due[i];
         if (i == 0) sb0.push_back(x);
         else        sb1.push_back(x);
      end
      @(posedge clk);
      #1;
      load_cache[i] = 1'b0;
      load_ad[i]    = 1'b0;
      ack_disp[i]   = 1'b0;
      check($sformatf("dram_en[%0d]", i), dram_en[i], out[i] && (cyc == acc_edge[i]));
      check($sformatf("busy[%0d]", i), busy[i], out[i] && (cyc < due[i]));
      check($sformatf("disp_valid[%0d]", i), disp_valid[i], out[i] && (cyc >= due[i]));
      check($sformatf("dram_addr[%0d]", i), dram_addr[i], m_addr[i]);
      check($sformatf("irac[%0d]", i), irac[i], m_irac[i]);
      check($sformatf("jrst0[%0d]", i), jrst0[i], m_jrst[i]);
      check($sformatf("io_legal[%0d]", i), io_legal[i], m_legal[i]);
   endtask

   task automatic idle(input int i, input int n);
      for (int k = 0; k < n; k++) step(i, 0, 0, '0, '0, 0, 0, 0, dram_data[i]);
   endtask

   task automatic ack_one(input int i);
      step(i, 0, 0, '0, '0, 0, 0, 1, dram_data[i]);
   endtask

   task automatic drain(input int i);
      for (int k = 0; k < 12 && out[i]; k++) step(i, 0, 0, '0, '0, 0, 0, 1, dram_data[i]);
   endtask

   task automatic check_zero(input int i, input string tag);
      check({tag, "_dram_en"}, dram_en[i], 0);
      check({tag, "_dram_addr"}, dram_addr[i], 0);
      check({tag, "_irac"}, irac[i], 0);
      check({tag, "_io_legal"}, io_legal[i], 0);
      check({tag, "_jrst0"}, jrst0[i], 0);
      check({tag, "_fields"}, {dram_a[i], dram_b[i], dram_j[i], par_err[i]}, 0);
      check({tag, "_disp_valid"}, disp_valid[i], 0);
      check({tag, "_busy"}, busy[i], 0);
   endtask

   // Monitor: every rising dispValid must match the oldest queued result and its due edge.
   always @(negedge clk) begin : monitor
      exp_t x;
      bit   have;
      for (int i = 0; i < 2; i++) begin
         if (disp_valid[i] === 1'b1 && prev_v[i] !== 1'b1) begin
            have = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            if (!have) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid[%0d]: got 1 expected 0 (cycle %0d)", i, cyc);
            end else begin
               x = (i == 0) ? sb0.pop_front() : sb1.pop_front();
               check($sformatf("res_a[%0d]", i), dram_a[i], x.a);
               check($sformatf("res_b[%0d]", i), dram_b[i], x.b);
               check($sformatf("res_j[%0d]", i), dram_j[i], x.j);
               check($sformatf("res_par[%0d]", i), par_err[i], x.par);
               check($sformatf("res_edge[%0d]", i), cyc, x.due);
            end
         end
         prev_v[i] = disp_valid[i];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         load_cache[i] = 0; load_ad[i] = 0; user_mode[i] = 0; user_io_en[i] = 0;
         ack_disp[i] = 0; cache_data[i] = '0; ad_word[i] = '0; dram_data[i] = '0;
         out[i] = 0; due[i] = 0; acc_edge[i] = 0; m_addr[i] = '0; m_irac[i] = '0;
         m_jrst[i] = 0; m_legal[i] = 0; prev_v[i] = 0;
      end
      #3;
      check_zero(0, "rst0");
      check_zero(1, "rst1");
      @(negedge clk);
      reset = 1'b0;

      // JRST 0 lookup, DRAM_LAT=1
      step(0, 1, 0, 36'o254000000000, '0, 0, 0, 0, 24'h5A0123);
      check("t1_addr", dram_addr[0], 13'b0101011000000);
      check("t1_jrst0", jrst0[0], 1);
      idle(0, 1);
      check("t1_valid_early", disp_valid[0], 0);
      idle(0, 1);
      check("t1_valid", disp_valid[0], 1);
      check("t1_a", dram_a[0], 4'h5);
      check("t1_b", dram_b[0], 4'hA);
      check("t1_j", dram_j[0], 11'h123);
      check("t1_par", par_err[0], 1);
      ack_one(0);

      // cache beats AD when both request
      step(0, 1, 1, 36'o200040000000, 36'o700140000000, 0, 0, 0, 24'h123456);
      check("t2_irac", irac[0], 3'd1);
      check("t2_ioclass", dram_addr[0][0], 0);
      check("t2_legal", io_legal[0], 0);
      idle(0, 2);
      ack_one(0);

      // I/O legality across user mode / user I/O enable
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, '0, 36'o700000000000, (k < 2), (k >= 1), 0, 24'($urandom));
         check("t3_legal", io_legal[0], (k != 0));
         check("t3_ioclass", dram_addr[0][0], 1);
         idle(0, 2);
         ack_one(0);
      end

      // DRAM_LAT=3: one-clock read strobe, loads ignored while busy
      step(1, 0, 1, '0, 36'o254040000000, 0, 0, 0, 24'hABCDEF);
      check("t4_en", dram_en[1], 1);
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 1, 36'o123456701234, 36'o765432107654, 0, 0, 0, 24'h000000);
         check("t4_en_low", dram_en[1], 0);
         check("t4_irac_held", irac[1], 3'd1);
         if (k == 3) check("t4_valid_early", disp_valid[1], 0);
         if (k == 4) check("t4_valid", disp_valid[1], 1);
      end
      ack_one(1);

      // back-to-back: ack and new load in the same cycle
      step(0, 1, 0, 36'o254000000000, '0, 0, 0, 0, 24'h111111);
      idle(0, 2);
      step(0, 1, 0, 36'o712340000000, '0, 0, 1, 1, 24'h765432);
      check("t5_en", dram_en[0], 1);
      check("t5_valid_low", disp_valid[0], 0);
      idle(0, 2);
      check("t5_valid", disp_valid[0], 1);
      ack_one(0);

      // randomized traffic on both latencies
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 300; n++) begin
            logic [35:0] w1, w2;
            w1 = rand_word();
            w2 = rand_word();
            step(i, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), w1, w2,
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 2) == 0), 24'($urandom));
         end
         drain(i);
      end
      check("sb0_empty", sb0.size(), 0);
      check("sb1_empty", sb1.size(), 0);

      // reset in the middle of a DRAM_LAT=3 wait
      step(1, 1, 0, 36'o777740000000, '0, 0, 1, 0, 24'h0F0F0F);
      idle(1, 1);
      check("t6_busy", busy[1], 1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_zero(1, "t6_async");
      for (int i = 0; i < 2; i++) begin
         out[i] = 0; m_addr[i] = '0; m_irac[i] = '0; m_jrst[i] = 0; m_legal[i] = 0;
      end
      sb0.delete();
      sb1.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         dram_data[1] = 24'($urandom);
         idle(1, 1);
      end
      check("t6_valid_after", disp_valid[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
